minesweeper_game_ctrl: RTL

//  Top-level sequencer for the 4x4 bomb-grid game. Latches a bomb count and places bombs one per

---
 rtl/minesweeper_game_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/minesweeper_game_ctrl.sv
// Game sequencer for the 4x4 bomb grid: bomb placement with collision
// probing, then the play phase with reveal tracking and WIN/LOSE detection.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_PLACE | placing nb bombs, one address test per cycle
// S_PLAY  | accepting cell picks (cell_ready high)
// S_WIN   | every safe cell revealed; holds until start
// S_LOSE  | a bomb was picked; holds until start
module minesweeper_game_ctrl #(
  parameter int N_CELLS = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IDX_W-1:0]   bomb_count,
  input  logic [IDX_W-1:0]   rand_idx,
  input  logic               cell_valid,
  input  logic [IDX_W-1:0]   cell_idx,
  output logic               cell_ready,
  output logic               busy,
  output logic [N_CELLS-1:0] bomb_grid,
  output logic [N_CELLS-1:0] revealed,
  output logic [IDX_W:0]     safe_count,
  output logic               game_over,
  output logic               win
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLACE = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [N_CELLS-1:0] bomb_grid_q, revealed_q;
  logic [IDX_W:0]     safe_count_q;
  logic [IDX_W-1:0]   nb_q, placed_q, cand_q;
  logic               probe_q;

  logic               start_ok;
  logic [IDX_W-1:0]   nb_clamped;
  logic [IDX_W-1:0]   place_addr;
  logic               place_free;
  logic [IDX_W-1:0]   placed_inc;
  logic               pick_fire, pick_bomb, pick_dup;
  logic [IDX_W:0]     safe_inc;
  logic [IDX_W:0]     win_target;

  // Decision logic shared by the state register and the datapath.
  always_comb begin
    start_ok   = start && (state_q == S_IDLE || state_q == S_WIN || state_q == S_LOSE);
    // bomb_count is IDX_W bits wide, so it can never exceed N_CELLS-1;
    // only the lower clamp needs logic.
    nb_clamped = (bomb_count == '0) ? IDX_W'(1) : bomb_count;
    place_addr = probe_q ? cand_q : rand_idx;
    place_free = !bomb_grid_q[place_addr];
    placed_inc = placed_q + 1'b1;
    pick_fire  = (state_q == S_PLAY) && cell_valid;
    pick_bomb  = bomb_grid_q[cell_idx];
    pick_dup   = revealed_q[cell_idx];
    safe_inc   = safe_count_q + 1'b1;
    win_target = (IDX_W+1)'(N_CELLS) - {1'b0, nb_q};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    cell_ready = 1'b0;
    busy       = 1'b0;
    game_over  = 1'b0;
    win        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_PLACE;
      end
      S_PLACE: begin
        busy = 1'b1;
        if (place_free && placed_inc == nb_q) state_d = S_PLAY;
      end
      S_PLAY: begin
        cell_ready = 1'b1;
        if (pick_fire) begin
          if (pick_bomb)                           state_d = S_LOSE;
          else if (!pick_dup && safe_inc == win_target) state_d = S_WIN;
        end
      end
      S_WIN: begin
        win = 1'b1;
        if (start_ok) state_d = S_PLACE;
      end
      S_LOSE: begin
        game_over = 1'b1;
        if (start_ok) state_d = S_PLACE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grid, reveal and counter datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      bomb_grid_q  <= '0;
      revealed_q   <= '0;
      safe_count_q <= '0;
      nb_q         <= '0;
      placed_q     <= '0;
      cand_q       <= '0;
      probe_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start_ok) begin
            bomb_grid_q  <= '0;
            revealed_q   <= '0;
            safe_count_q <= '0;
            placed_q     <= '0;
            probe_q      <= 1'b0;
            nb_q         <= nb_clamped;
          end
        end
        S_PLACE: begin
          if (place_free) begin
            bomb_grid_q[place_addr] <= 1'b1;
            placed_q                <= placed_inc;
            probe_q                 <= 1'b0;
          end else begin
            // Linear probe to the next cell, wrapping through IDX_W-bit overflow.
            cand_q  <= place_addr + 1'b1;
            probe_q <= 1'b1;
          end
        end
        S_PLAY: begin
          if (pick_fire && !pick_bomb && !pick_dup) begin
            revealed_q[cell_idx] <= 1'b1;
            safe_count_q         <= safe_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bomb_grid  = bomb_grid_q;
  assign revealed   = revealed_q;
  assign safe_count = safe_count_q;

endmodule
